// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one instance per requester.
// The requester drives the request fields through the master modport.
// The arbiter returns grant and read data through the slave modport.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              lock;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, lock,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port 128x32 data memory.
// r0 is the CPU load/store path and r1 is the debug/DMA loader.
// Arbitration is round-robin. A requester may hold a lock for atomic
// read-modify-write sequences, but the lock is bounded to LOCK_MAX cycles.
// Optional grant/stall statistics counters are built when DMEM_ARB_STATS_EN
// is defined; without it those ports do not exist.
module dmem_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     r0,
    dmem_arbiter_if.slave     r1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_we2,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_gnt0,
    output logic [15:0]       stat_gnt1,
    output logic [15:0]       stat_stall
`endif
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t            state_q;
    logic              rrPtr_q;
    logic [CNT_W-1:0]  lockCnt_q;
    logic [CNT_W-1:0]  lockCnt_d;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              gnt0;
    logic              gnt1;
    logic              ownerLock;

    // lockCnt_q counts cycles of ownership including the cycle that took the
    // lock; the forced release happens on the edge where that count reaches
    // LOCK_MAX, so the owner gets at most LOCK_MAX consecutive grants.
    assign lockCnt_d = lockCnt_q + CNT_W'(1);
    assign ownerLock = (state_q == OWN0) ? r0.lock : r1.lock;

    // Grant decision: owner-only while locked, otherwise the lone requester or rr_ptr on conflict.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state_q)
                OWN0: gnt0 = r0.req;
                OWN1: gnt1 = r1.req;
                default: begin
                    if (r0.req && r1.req) begin
                        gnt0 = ~rrPtr_q;
                        gnt1 = rrPtr_q;
                    end else begin
                        gnt0 = r0.req;
                        gnt1 = r1.req;
                    end
                end
            endcase
        end
    end

    // Memory port mux: the granted requester's fields, or all zero with no grant.
    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_we2        = 1'b0;
        if (gnt0) begin
            mem_address    = r0.addr;
            mem_write_data = r0.wdata;
            mem_we2        = r0.we;
        end else if (gnt1) begin
            mem_address    = r1.addr;
            mem_write_data = r1.wdata;
            mem_we2        = r1.we;
        end
    end

    // Arbitration FSM with round-robin pointer, lock counter and registered read return.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rrPtr_q   <= 1'b0;
            lockCnt_q <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= gnt0 & ~r0.we;
            rvalid1_q <= gnt1 & ~r1.we;
            if (gnt0 && !r0.we) begin
                rdata0_q <= mem_read_data;
            end
            if (gnt1 && !r1.we) begin
                rdata1_q <= mem_read_data;
            end

            case (state_q)
                OWN0, OWN1: begin
                    lockCnt_q <= lockCnt_d;
                    if (lockCnt_d == LOCK_LAST) begin
                        state_q   <= IDLE;
                        lockCnt_q <= '0;
                        rrPtr_q   <= (state_q == OWN0);
                    end else if (!ownerLock) begin
                        state_q   <= IDLE;
                        lockCnt_q <= '0;
                    end
                end
                default: begin
                    if (gnt0 || gnt1) begin
                        rrPtr_q <= gnt0;
                        if ((gnt0 && r0.lock) || (gnt1 && r1.lock)) begin
                            // With LOCK_MAX of 1 the taking cycle already uses the whole budget.
                            if (LOCK_LAST != CNT_W'(1)) begin
                                state_q   <= gnt0 ? OWN0 : OWN1;
                                lockCnt_q <= CNT_W'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign r0.gnt    = gnt0;
    assign r1.gnt    = gnt1;
    assign r0.rvalid = rvalid0_q;
    assign r1.rvalid = rvalid1_q;
    assign r0.rdata  = rdata0_q;
    assign r1.rdata  = rdata1_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] statGnt0_q;
    logic [15:0] statGnt1_q;
    logic [15:0] statStall_q;
    logic        stall;

    assign stall = (r0.req && !gnt0) || (r1.req && !gnt1);

    // Saturating grant and stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            statGnt0_q  <= '0;
            statGnt1_q  <= '0;
            statStall_q <= '0;
        end else begin
            if (gnt0 && statGnt0_q != 16'hFFFF) begin
                statGnt0_q <= statGnt0_q + 16'd1;
            end
            if (gnt1 && statGnt1_q != 16'hFFFF) begin
                statGnt1_q <= statGnt1_q + 16'd1;
            end
            if (stall && statStall_q != 16'hFFFF) begin
                statStall_q <= statStall_q + 16'd1;
            end
        end
    end

    assign stat_gnt0  = statGnt0_q;
    assign stat_gnt1  = statGnt1_q;
    assign stat_stall = statStall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter.
// A behavioural model (owner / favoured requester / shadow memory) predicts
// the grants, memory port and read return every cycle. Directed sequences
// carry hand-computed literal expectations that pin the model itself.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r0If ();
    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r1If ();

    logic [ADDR_W-1:0] memAddress;
    logic [DATA_W-1:0] memWriteData;
    logic [DATA_W-1:0] memReadData;
    logic              memWe2;

    logic [DATA_W-1:0] memArr [0:127];
    logic [DATA_W-1:0] refMem [0:127];

    int checks = 0;
    int errors = 0;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] statGnt0;
    logic [15:0] statGnt1;
    logic [15:0] statStall;
`endif

    dmem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .r0            (r0If),
        .r1            (r1If),
        .mem_address   (memAddress),
        .mem_write_data(memWriteData),
        .mem_we2       (memWe2),
        .mem_read_data (memReadData)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_gnt0     (statGnt0),
        .stat_gnt1     (statGnt1),
        .stat_stall    (statStall)
`endif
    );

    // The data memory: combinational read, write on the clock edge.
    assign memReadData = memArr[memAddress];

    always @(posedge clk) begin
        if (memWe2) begin
            memArr[memAddress] <= memWriteData;
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            memArr[i] = 32'hA500_0000 | 32'(i);
            refMem[i] = 32'hA500_0000 | 32'(i);
        end
        r0If.req = 1'b0; r0If.we = 1'b0; r0If.addr = '0; r0If.wdata = '0; r0If.lock = 1'b0;
        r1If.req = 1'b0; r1If.we = 1'b0; r1If.addr = '0; r1If.wdata = '0; r1If.lock = 1'b0;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle of stimulus; returns just after the middle of the cycle.
    task automatic applyStimulus(
        input logic rst,
        input logic q0, input logic w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0, input logic l0,
        input logic q1, input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1, input logic l1
    );
        @(posedge clk);
        #1;
        reset = rst;
        r0If.req = q0; r0If.we = w0; r0If.addr = a0; r0If.wdata = d0; r0If.lock = l0;
        r1If.req = q1; r1If.we = w1; r1If.addr = a1; r1If.wdata = d1; r1If.lock = l1;
        @(negedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0);
    endtask

    // Behavioural model and per-cycle comparison at the middle of each cycle.
    initial begin : compareProc
        int owner;
        int held;
        int favour;
        int winner;
        logic eg0, eg1, ew, lk;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic expRv0, expRv1;
        logic [DATA_W-1:0] expRd0, expRd1;

        owner = -1; held = 0; favour = 0;
        expRv0 = 1'b0; expRv1 = 1'b0; expRd0 = '0; expRd1 = '0;
        forever begin
            @(negedge clk);
            eg0 = 1'b0;
            eg1 = 1'b0;
            if (!reset) begin
                if (owner == 0) begin
                    eg0 = r0If.req;
                end else if (owner == 1) begin
                    eg1 = r1If.req;
                end else if (r0If.req && r1If.req) begin
                    eg0 = (favour == 0);
                    eg1 = (favour == 1);
                end else begin
                    eg0 = r0If.req;
                    eg1 = r1If.req;
                end
            end
            ea = '0; ed = '0; ew = 1'b0;
            if (eg0) begin
                ea = r0If.addr; ed = r0If.wdata; ew = r0If.we;
            end else if (eg1) begin
                ea = r1If.addr; ed = r1If.wdata; ew = r1If.we;
            end

            checkOutput("r0_gnt", 32'(r0If.gnt), 32'(eg0));
            checkOutput("r1_gnt", 32'(r1If.gnt), 32'(eg1));
            checkOutput("mem_we2", 32'(memWe2), 32'(ew));
            checkOutput("mem_address", 32'(memAddress), 32'(ea));
            checkOutput("mem_write_data", memWriteData, ed);
            if (!reset) begin
                checkOutput("r0_rvalid", 32'(r0If.rvalid), 32'(expRv0));
                checkOutput("r1_rvalid", 32'(r1If.rvalid), 32'(expRv1));
                checkOutput("r0_rdata", r0If.rdata, expRd0);
                checkOutput("r1_rdata", r1If.rdata, expRd1);
            end

            if (reset) begin
                owner = -1; held = 0; favour = 0;
                expRv0 = 1'b0; expRv1 = 1'b0; expRd0 = '0; expRd1 = '0;
            end else begin
                expRv0 = eg0 && !r0If.we;
                expRv1 = eg1 && !r1If.we;
                if (expRv0) expRd0 = refMem[r0If.addr];
                if (expRv1) expRd1 = refMem[r1If.addr];
                if (eg0 && r0If.we) refMem[r0If.addr] = r0If.wdata;
                if (eg1 && r1If.we) refMem[r1If.addr] = r1If.wdata;
                winner = eg0 ? 0 : (eg1 ? 1 : -1);
                if (owner < 0) begin
                    if (winner >= 0) begin
                        favour = 1 - winner;
                        lk = (winner == 0) ? r0If.lock : r1If.lock;
                        if (lk) begin
                            held  = 1;
                            owner = (held >= LOCK_MAX) ? -1 : winner;
                        end
                    end
                end else begin
                    held++;
                    lk = (owner == 0) ? r0If.lock : r1If.lock;
                    if (held >= LOCK_MAX) begin
                        favour = 1 - owner;
                        owner  = -1;
                    end else if (!lk) begin
                        owner = -1;
                    end
                end
            end
        end
    end

    // Directed sequences with hand-computed expectations.
    initial begin : stimulusProc
        // Reset cycle with both requesting: nothing may reach the memory.
        applyStimulus(1'b1, 1'b1, 1'b1, 7'd5, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 7'd6, 32'h1111_1111, 1'b0);
        checkOutput("reset_gnt0", 32'(r0If.gnt), 32'd0);
        checkOutput("reset_gnt1", 32'(r1If.gnt), 32'd0);
        checkOutput("reset_we", 32'(memWe2), 32'd0);
        checkOutput("reset_addr", 32'(memAddress), 32'd0);
        idleCycle();
        checkOutput("post_reset_rvalid0", 32'(r0If.rvalid), 32'd0);
        checkOutput("post_reset_rdata0", r0If.rdata, 32'd0);

        // Write then read back address 5 from r0.
        applyStimulus(1'b0, 1'b1, 1'b1, 7'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0);
        checkOutput("wr5_gnt0", 32'(r0If.gnt), 32'd1);
        checkOutput("wr5_we", 32'(memWe2), 32'd1);
        checkOutput("wr5_addr", 32'(memAddress), 32'd5);
        applyStimulus(1'b0, 1'b1, 1'b0, 7'd5, 32'd0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0);
        checkOutput("rd5_gnt0", 32'(r0If.gnt), 32'd1);
        checkOutput("rd5_we", 32'(memWe2), 32'd0);
        idleCycle();
        checkOutput("rd5_rvalid", 32'(r0If.rvalid), 32'd1);
        checkOutput("rd5_rdata", r0If.rdata, 32'hDEAD_BEEF);
        idleCycle();
        checkOutput("rd5_rvalid_drop", 32'(r0If.rvalid), 32'd0);
        checkOutput("rd5_rdata_hold", r0If.rdata, 32'hDEAD_BEEF);

        // Round-robin: both read every cycle after reset.
        applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 7'd5, 32'd0, 1'b0, 1'b1, 1'b0, 7'd6, 32'd0, 1'b0);
            checkOutput("rr_gnt0", 32'(r0If.gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("rr_gnt1", 32'(r1If.gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i == 1) checkOutput("rr_rdata0", r0If.rdata, 32'hDEAD_BEEF);
            if (i == 2) checkOutput("rr_rdata1", r1If.rdata, 32'hA500_0006);
        end
        idleCycle();

        // r1 lock held with r0 competing: four r1 grants, forced release, then r0.
        applyStimulus(1'b0, 1'b1, 1'b0, 7'd5, 32'd0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 7'd5, 32'd0, 1'b0, 1'b1, 1'b0, 7'd7, 32'd0, 1'b1);
            checkOutput("lock_gnt1", 32'(r1If.gnt), (i < LOCK_MAX) ? 32'd1 : 32'd0);
            checkOutput("lock_gnt0", 32'(r0If.gnt), (i == LOCK_MAX) ? 32'd1 : 32'd0);
        end
        idleCycle();

        // r0 read-modify-write of address 9 under lock while r1 waits.
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 1'b0, 7'd4, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 7'd9, 32'd0, 1'b1, 1'b1, 1'b0, 7'd4, 32'd0, 1'b0);
        checkOutput("rmw_rd_gnt0", 32'(r0If.gnt), 32'd1);
        checkOutput("rmw_rd_gnt1", 32'(r1If.gnt), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 7'd9, 32'hA500_000A, 1'b0, 1'b1, 1'b0, 7'd4, 32'd0, 1'b0);
        checkOutput("rmw_wr_gnt0", 32'(r0If.gnt), 32'd1);
        checkOutput("rmw_wr_gnt1", 32'(r1If.gnt), 32'd0);
        checkOutput("rmw_old_data", r0If.rdata, 32'hA500_0009);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 1'b0, 7'd4, 32'd0, 1'b0);
        checkOutput("rmw_r1_gnt", 32'(r1If.gnt), 32'd1);
        idleCycle();
        checkOutput("rmw_mem9", memArr[9], 32'hA500_000A);

        // Reset while r1 holds a lock and attempts a write to address 3.
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 1'b0, 7'd2, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 1'b1, 7'd3, 32'h0000_1234, 1'b1);
        checkOutput("rst_lock_we", 32'(memWe2), 32'd0);
        checkOutput("rst_lock_gnt1", 32'(r1If.gnt), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 7'd1, 32'd0, 1'b0, 1'b1, 1'b0, 7'd2, 32'd0, 1'b0);
        checkOutput("rst_lock_after_gnt0", 32'(r0If.gnt), 32'd1);
        checkOutput("rst_lock_after_rvalid1", 32'(r1If.rvalid), 32'd0);
        checkOutput("rst_lock_mem3", memArr[3], 32'hA500_0003);
        idleCycle();

`ifdef DMEM_ARB_STATS_EN
        // Three conflicting cycles after reset.
        applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 7'd1, 32'd0, 1'b0, 1'b1, 1'b0, 7'd2, 32'd0, 1'b0);
        end
        idleCycle();
        checkOutput("stat_stall", 32'(statStall), 32'd3);
        checkOutput("stat_gnt_sum", 32'(statGnt0) + 32'(statGnt1), 32'd3);
`endif

        idleCycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
